ram_bist_ctrl: RTL and testbench

Parametrised write-then-read self-test controller for a single-port synchronous RAM with configurable data width, depth and read latency. On `start` it writes an address-derived pattern to every word, reads every word back, compares it against the expected value and reports pass/fail, an error count and the first failing address. It is the generalised successor of the fixed 32-word RAM read/write exerciser in the IP RAM example design. It drives an external RAM port, so the same controller covers on-chip IP RAMs and behavioural models.

---
 rtl/ram_bist_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// Write-then-read self-test controller for a single-port synchronous RAM.
// Define RAM_BIST_INV_PASS_EN to add a second pass using the inverted pattern.
module ram_bist_ctrl #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 5,
  parameter int unsigned       DEPTH  = 32,
  parameter int unsigned       RD_LAT = 1,
  parameter logic [DATA_W-1:0] SEED   = '0,
  parameter int unsigned       ERR_W  = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] exp;
  } rd_tag_t;

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic              inv);
    logic [DATA_W-1:0] p;
    p = DATA_W'(a) + SEED;
    return inv ? ~p : p;
  endfunction

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic                first_q, first_d;
  logic                inv_q, inv_d;
  logic [1:0]          drain_q, drain_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  rd_tag_t             pipe_q [RD_LAT];
  rd_tag_t             head;
  rd_tag_t             tail;
  logic                mismatch;

  // Tag for the read issued this cycle; it reaches the tail when its data returns.
  assign head     = '{vld: (state_q == S_READ), adr: ram_addr_q,
                      exp: pattern(ram_addr_q, inv_q)};
  assign tail     = pipe_q[RD_LAT-1];
  assign mismatch = tail.vld && (ram_rdata != tail.exp);

  always_comb begin
    // NOTE: every variable gets a default before the case, so no latch can be inferred.
    state_d     = state_q;
    ram_addr_d  = '0;
    drain_d     = drain_q;
    inv_d       = inv_q;
    err_cnt_d   = err_cnt_q;
    fail_addr_d = fail_addr_q;
    first_d     = first_q;
    pass_d      = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WRITE;
          inv_d   = 1'b0;
        end
      end
      S_WRITE: begin
        if (ram_addr_q == LAST_ADDR) state_d = S_READ;
        else                         ram_addr_d = ram_addr_q + ADDR_W'(1);
      end
      S_READ: begin
        if (ram_addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
`ifdef RAM_BIST_INV_PASS_EN
          if (!inv_q) begin
            state_d = S_WRITE;
            inv_d   = 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_q == S_IDLE && start) begin
      err_cnt_d   = '0;
      fail_addr_d = '0;
      first_d     = 1'b0;
      pass_d      = 1'b0;
    end else if (mismatch) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
      if (!first_q) begin
        first_d     = 1'b1;
        fail_addr_d = tail.adr;
      end
    end

    // The final compare lands on the same edge that enters DONE.
    if (state_d == S_DONE) pass_d = (err_cnt_d == '0);

    busy_d      = (state_d == S_WRITE) || (state_d == S_READ) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    ram_we_d    = (state_d == S_WRITE);
    ram_wdata_d = (state_d == S_WRITE) ? pattern(ram_addr_d, inv_d) : '0;
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      first_q     <= 1'b0;
      inv_q       <= 1'b0;
      drain_q     <= 2'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_addr_q <= fail_addr_d;
      first_q     <= first_d;
      inv_q       <= inv_d;
      drain_q     <= drain_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // NOTE: the delay line is reset because its valid bits gate the compare after a mid-test reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q[0] <= head;
      for (int i = 1; i < int'(RD_LAT); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Directed bench for ram_bist_ctrl: three configurations, each with its own RAM model.
module tb_ram_bist_ctrl;

`ifdef RAM_BIST_INV_PASS_EN
  localparam bit INV    = 1'b1;
  localparam int DONE_A = 131;  // DEPTH=32, RD_LAT=1, two passes
  localparam int DONE_B = 69;   // DEPTH=16, RD_LAT=2, two passes
`else
  localparam bit INV    = 1'b0;
  localparam int DONE_A = 66;
  localparam int DONE_B = 35;
`endif

  logic clk, rst_n, start;
  int   sel;
  int   fault_mode;  // u2 RAM: 0 ideal, 1 addr 5 bit 0 stuck-at-1, 2 reads return 0
  int   total, bad;
  logic busy_log [0:400];

  // u0: default configuration
  logic       busy0, done0, pass0, we0;
  logic [7:0] err0, wd0, rd0, rq0;
  logic [4:0] fa0, addr0;
  logic [7:0] mem0 [32];

  // u1: RD_LAT=2, DEPTH=16, ADDR_W=4, SEED=F8
  logic       busy1, done1, pass1, we1;
  logic [7:0] err1, wd1, rd1, rq1a, rq1b;
  logic [3:0] fa1, addr1;
  logic [7:0] mem1 [16];

  // u2: SEED=1, ERR_W=4
  logic       busy2, done2, pass2, we2;
  logic [3:0] err2;
  logic [7:0] wd2, rd2, rq2;
  logic [4:0] fa2, addr2;
  logic [7:0] mem2 [32];

  logic       busy_m, done_m, pass_m;
  logic [7:0] err_m;
  logic [4:0] fa_m;

  ram_bist_ctrl u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start && sel == 0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_addr(fa0),
    .ram_we(we0), .ram_addr(addr0), .ram_wdata(wd0), .ram_rdata(rd0)
  );

  ram_bist_ctrl #(.DATA_W(8), .ADDR_W(4), .DEPTH(16), .RD_LAT(2), .SEED(8'hF8), .ERR_W(8)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start && sel == 1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .fail_addr(fa1),
    .ram_we(we1), .ram_addr(addr1), .ram_wdata(wd1), .ram_rdata(rd1)
  );

  ram_bist_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(32), .RD_LAT(1), .SEED(8'h01), .ERR_W(4)) u2 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start && sel == 2),
    .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2), .fail_addr(fa2),
    .ram_we(we2), .ram_addr(addr2), .ram_wdata(wd2), .ram_rdata(rd2)
  );

  always @(posedge clk) begin
    if (we0) mem0[addr0] <= wd0;
    rq0 <= mem0[addr0];
    if (we1) mem1[addr1] <= wd1;
    rq1a <= mem1[addr1];
    rq1b <= rq1a;
    if (we2) mem2[addr2] <= (fault_mode == 1 && addr2 == 5'd5) ? (wd2 | 8'h01) : wd2;
    rq2 <= mem2[addr2];
  end

  assign rd0 = rq0;
  assign rd1 = rq1b;
  assign rd2 = (fault_mode == 2) ? 8'h00 : rq2;

  always_comb begin
    busy_m = busy0; done_m = done0; pass_m = pass0; err_m = err0; fa_m = fa0;
    if (sel == 1) begin
      busy_m = busy1; done_m = done1; pass_m = pass1; err_m = err1; fa_m = {1'b0, fa1};
    end else if (sel == 2) begin
      busy_m = busy2; done_m = done2; pass_m = pass2; err_m = {4'h0, err2}; fa_m = fa2;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] word(input logic [7:0] v);
    return INV ? ~v : v;
  endfunction

  // Pulse start into the selected instance; n is the cycle (after the start edge) holding done.
  task automatic run_test(input int s, output int n);
    sel = s;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      busy_log[i] = busy_m;
      if (done_m) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, ndone, d1, d2;
    total = 0; bad = 0;
    sel = 0; fault_mode = 0;
    start = 1'b0; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy0, done0, pass0, err0, fa0, we0, addr0, wd0}, 32'h0);
    rst_n = 1'b1;

    // Reset asserted in the middle of WRITE
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_write_we", we0, 1);
    check("mid_write_addr", addr0, 9);
    #2 rst_n = 1'b0;
    #1 check("mid_reset_outputs", {busy0, done0, pass0, err0, fa0, we0, addr0, wd0}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done0) ndone++;
    end
    check("no_done_after_reset", ndone, 0);

    // Clean run on the default configuration
    run_test(0, n);
    check("clean_done_cycle", n, DONE_A);
    check("clean_pass", pass_m, 1);
    check("clean_err_cnt", err_m, 0);
    check("clean_fail_addr", fa_m, 0);
    check("clean_busy_first", busy_log[1], 1);
    check("clean_busy_last", busy_log[DONE_A-1], 1);
    check("clean_busy_at_done", busy_log[DONE_A], 0);
    for (int a = 0; a < 32; a++) check($sformatf("clean_word_%0d", a), mem0[a], word(8'(a)));
    @(negedge clk);
    check("done_one_cycle", done_m, 0);
    repeat (3) @(negedge clk);
    check("pass_holds", pass_m, 1);

    // Stuck-at-1 on bit 0 of address 5 (SEED=1 makes P(5)=06)
    fault_mode = 1;
    run_test(2, n);
    check("fault_done_cycle", n, DONE_A);
    check("fault_pass", pass_m, 0);
    check("fault_err_cnt", err_m, 1);
    check("fault_fail_addr", fa_m, 5);

    // Read latency 2 with pattern wrap-around at a=8
    run_test(1, n);
    check("wrap_done_cycle", n, DONE_B);
    check("wrap_pass", pass_m, 1);
    check("wrap_err_cnt", err_m, 0);
    check("wrap_word_7", mem1[7], word(8'hFF));
    check("wrap_word_8", mem1[8], word(8'h00));
    check("wrap_word_15", mem1[15], word(8'h07));

    // Every read returns zero: counter saturates, first failure at address 0
    fault_mode = 2;
    run_test(2, n);
    check("sat_done_cycle", n, DONE_A);
    check("sat_pass", pass_m, 0);
    check("sat_err_cnt", err_m, 8'h0F);
    check("sat_fail_addr", fa_m, 0);
    fault_mode = 0;

    // start held high: one test per IDLE visit, never restarted from DONE
    sel = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    ndone = 0; d1 = 0; d2 = 0;
    for (int i = 1; i <= 2 * DONE_A + 6; i++) begin
      @(negedge clk);
      busy_log[i] = busy0;
      if (done0) begin
        ndone++;
        if (d1 == 0) d1 = i;
        else if (d2 == 0) d2 = i;
      end
    end
    start = 1'b0;
    check("hold_done_count", ndone, 2);
    check("hold_first_done", d1, DONE_A);
    check("hold_second_done", d2, 2 * DONE_A + 1);
    check("hold_idle_gap", busy_log[DONE_A+1], 0);
    check("hold_restart_busy", busy_log[DONE_A+2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
